imem_loader: RTL

Program loader on the instruction-fetch side of the CPU. It accepts a program as a stream of 32-bit instruction words, writes them into instruction memory starting at the entry point, and checks them against a trailing checksum word. If the checksum matches, it starts the CPU with a one-cycle `INT` pulse and a fixed `entryPoint`. Fetch reads the instruction memory; this block is the writer at the other end of that memory.

---
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader.sv | 135 +++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Bundle of the loader's control, stream and instruction-memory write signals.
// Stream handshake: a word moves in any cycle where s_valid && s_ready is high
// at the rising edge. s_ready comes from a register and never looks at s_valid.
// A producer holds s_data stable while s_valid is high and s_ready is low.
interface imem_loader_if;
   logic        start;
   logic [7:0]  len;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        INT;
   logic [31:0] entryPoint;
   logic        busy;
   logic        done;
   logic        err;

   // Side that requests loads and supplies the stream.
   modport master (
      output start, len, s_valid, s_data,
      input  s_ready, mem_we, mem_addr, mem_wdata, INT, entryPoint, busy, done, err
   );

   // The loader itself.
   modport slave (
      input  start, len, s_valid, s_data,
      output s_ready, mem_we, mem_addr, mem_wdata, INT, entryPoint, busy, done, err
   );
endinterface

// File: rtl/imem_loader.sv
// Program loader: writes a word stream into instruction memory starting at
// ENTRY, checks a trailing checksum word and then starts the CPU with a
// one-cycle INT pulse. All outputs are registered by the state machine.
module imem_loader #(
   parameter logic [31:0] ENTRY     = 32'd128,
   parameter int          MAX_WORDS = 64
) (
   input  logic         clk,
   input  logic         rst,
   imem_loader_if.slave bus,
   output logic [2:0]   o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_KICK  = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   state_t      r_state;
   logic [7:0]  r_len;
   logic [7:0]  r_cnt;
   logic [31:0] r_sum;
   logic        r_s_ready;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic        r_int;
   logic        r_busy;
   logic        r_done;
   logic        r_err;

   logic        w_hs;
   logic        w_len_bad;

   assign w_hs      = bus.s_valid && r_s_ready;
   assign w_len_bad = (bus.len == 8'd0) || (int'(bus.len) > MAX_WORDS);

   assign bus.s_ready    = r_s_ready;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_mem_wdata;
   assign bus.INT        = r_int;
   assign bus.entryPoint = ENTRY;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.err        = r_err;
   assign o_dbg_state    = r_state;

   // Load state machine; every output is set here for the cycle after the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_len       <= 8'd0;
         r_cnt       <= 8'd0;
         r_sum       <= 32'd0;
         r_s_ready   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_int       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         // Write strobe and start pulse are single-cycle unless re-armed below.
         r_mem_we <= 1'b0;
         r_int    <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (bus.start) begin
                  if (w_len_bad) begin
                     r_state   <= S_ERR;
                     r_s_ready <= 1'b0;
                     r_busy    <= 1'b0;
                     r_done    <= 1'b0;
                     r_err     <= 1'b1;
                  end else begin
                     r_state   <= S_LOAD;
                     r_len     <= bus.len;
                     r_cnt     <= 8'd0;
                     r_sum     <= 32'd0;
                     r_s_ready <= 1'b1;
                     r_busy    <= 1'b1;
                     r_done    <= 1'b0;
                     r_err     <= 1'b0;
                  end
               end
            end
            S_LOAD: begin
               if (w_hs) begin
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= ENTRY + {22'd0, r_cnt, 2'b00};
                  r_mem_wdata <= bus.s_data;
                  r_sum       <= r_sum + bus.s_data;
                  r_cnt       <= r_cnt + 8'd1;
                  // s_ready stays high: the checksum word follows directly.
                  if (r_cnt == r_len - 8'd1) begin
                     r_state <= S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               if (w_hs) begin
                  r_s_ready <= 1'b0;
                  if (bus.s_data == r_sum) begin
                     r_state <= S_KICK;
                     r_int   <= 1'b1;
                  end else begin
                     r_state <= S_ERR;
                     r_busy  <= 1'b0;
                     r_err   <= 1'b1;
                  end
               end
            end
            S_KICK: begin
               r_state <= S_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            default: begin
               r_state   <= S_IDLE;
               r_s_ready <= 1'b0;
               r_busy    <= 1'b0;
               r_done    <= 1'b0;
               r_err     <= 1'b0;
            end
         endcase
      end
   end

endmodule
